// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and error codes.
package mem_pkg;

    // Access size, taken from SignExM
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Handshake FSM states
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // Error code carried to writeback in mem_err_w
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // True when the access cannot be done as one aligned bus word access.
    // The reserved size code 2'b11 is treated as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads. Purely combinational.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate the datum on every lane it could land in, enable the right lanes
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits
    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = {{16{sign_ext & ld_half[15]}}, ld_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// Pipeline MEM stage: drives the data-memory req/ack port, stalls upstream while
// an access is outstanding, and registers results into the M/W register.
module memory_cycle
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        Memory_selectorM,
    input  logic [2:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic        MuxsignM,
    input  logic        MUXWDMemwriteM,
    input  logic [1:0]  SignExM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] Immediate_valueM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] PCPlus_offsetM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        RegWriteW,
    output logic [2:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] PCPlus_offsetW,
    output logic [31:0] Immediate_valueW,
    output logic [1:0]  mem_err_w
);

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misaligned;
    logic             access;
    logic             timed_out;
    logic [3:0]       lane_be;
    logic [31:0]      load_data;

    assign misaligned = Memory_selectorM & is_misaligned(SignExM, ALU_ResultM[1:0]);
    assign access     = Memory_selectorM & ~misaligned;
    assign dmem_addr  = {ALU_ResultM[31:2], 2'b00};
    assign dmem_we    = dmem_req & MemWriteM;
    assign dmem_be    = dmem_req ? lane_be : 4'b0000;

    load_store_align u_align (
        .size       (SignExM),
        .addr_lo    (ALU_ResultM[1:0]),
        .sign_ext   (MuxsignM),
        .store_data (MUXWDMemwriteM ? Immediate_valueM : WriteDataM),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    // Handshake FSM next state, request and stall; everything is quiet while in reset
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dmem_req  = 1'b0;
        stall_m   = 1'b0;
        timed_out = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        dmem_req = 1'b1;
                        if (!dmem_ack) begin
                            stall_m = 1'b1;
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    dmem_req = 1'b1;
                    // Ack takes priority over an expiring counter
                    if (dmem_ack) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        timed_out = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end else begin
                        stall_m = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // M/W register: bubble while stalled, otherwise capture with any error outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW        <= 1'b0;
            ResultSrcW       <= '0;
            RD_W             <= '0;
            ALU_ResultW      <= '0;
            ReadDataW        <= '0;
            PCPlus4W         <= '0;
            PCPlus_offsetW   <= '0;
            Immediate_valueW <= '0;
            mem_err_w        <= ERR_NONE;
        end else if (stall_m) begin
            RegWriteW <= 1'b0;
            mem_err_w <= ERR_NONE;
        end else begin
            ResultSrcW       <= ResultSrcM;
            RD_W             <= RD_M;
            ALU_ResultW      <= ALU_ResultM;
            ReadDataW        <= load_data;
            PCPlus4W         <= PCPlus4M;
            PCPlus_offsetW   <= PCPlus_offsetM;
            Immediate_valueW <= Immediate_valueM;
            if (misaligned) begin
                RegWriteW <= 1'b0;
                mem_err_w <= ERR_MISALIGN;
            end else if (timed_out) begin
                RegWriteW <= 1'b0;
                mem_err_w <= ERR_TIMEOUT;
            end else begin
                RegWriteW <= RegWriteM;
                mem_err_w <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Randomized self-checking bench for memory_cycle against a transaction-level model.
module tb_memory_cycle;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, Memory_selectorM, MuxsignM, MUXWDMemwriteM;
    logic [2:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [1:0]  SignExM;
    logic [31:0] ALU_ResultM, WriteDataM, Immediate_valueM, PCPlus4M, PCPlus_offsetM;
    logic        dmem_req, dmem_we, dmem_ack, stall_m;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        RegWriteW;
    logic [2:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, PCPlus_offsetW, Immediate_valueW;
    logic [1:0]  mem_err_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_cycle #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .RegWriteM        (RegWriteM),
        .MemWriteM        (MemWriteM),
        .Memory_selectorM (Memory_selectorM),
        .ResultSrcM       (ResultSrcM),
        .RD_M             (RD_M),
        .MuxsignM         (MuxsignM),
        .MUXWDMemwriteM   (MUXWDMemwriteM),
        .SignExM          (SignExM),
        .ALU_ResultM      (ALU_ResultM),
        .WriteDataM       (WriteDataM),
        .Immediate_valueM (Immediate_valueM),
        .PCPlus4M         (PCPlus4M),
        .PCPlus_offsetM   (PCPlus_offsetM),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .stall_m          (stall_m),
        .RegWriteW        (RegWriteW),
        .ResultSrcW       (ResultSrcW),
        .RD_W             (RD_W),
        .ALU_ResultW      (ALU_ResultW),
        .ReadDataW        (ReadDataW),
        .PCPlus4W         (PCPlus4W),
        .PCPlus_offsetW   (PCPlus_offsetW),
        .Immediate_valueW (Immediate_valueW),
        .mem_err_w        (mem_err_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_misaligned(input int sz, input int unsigned addr);
        if (sz == 0) return 1'b0;
        if (sz == 1) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input int unsigned addr);
        if (sz == 0) return 4'(1 << (addr % 4));
        if (sz == 1) return 4'(3 << (addr % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input int unsigned d);
        if (sz == 0) return (d % 256) * 32'h0101_0101;
        if (sz == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input int unsigned addr, input bit sgn,
                                           input int unsigned rdata);
        int unsigned v;
        v = rdata >> (8 * (addr % 4));
        if (sz == 0) begin
            v = v % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Apply one M-stage instruction at a negedge; ack arrives d cycles after the request
    task automatic run_instr(input bit rw, input bit we, input bit sel, input logic [2:0] rs,
                             input logic [4:0] rd, input bit sgn, input bit mux, input int sz,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [31:0] imm, input logic [31:0] pc4,
                             input logic [31:0] pco, input logic [31:0] rdata, input int d);
        bit mis, acc, tmo, done, exp_stall;
        int stalls;
        mis = sel && m_misaligned(sz, alu);
        acc = sel && !mis;
        tmo = acc && (d > TMO);
        done = 1'b0;
        stalls = 0;
        RegWriteM = rw;  MemWriteM = we;  Memory_selectorM = sel;  ResultSrcM = rs;
        RD_M = rd;  MuxsignM = sgn;  MUXWDMemwriteM = mux;  SignExM = 2'(sz);
        ALU_ResultM = alu;  WriteDataM = wd;  Immediate_valueM = imm;
        PCPlus4M = pc4;  PCPlus_offsetM = pco;  dmem_rdata = rdata;
        for (int k = 0; k <= TMO + 1; k++) begin
            dmem_ack = acc && (k == d);
            #1;
            exp_stall = acc && (k != d) && (k < TMO);
            check("stall_m", 32'(stall_m), 32'(exp_stall));
            check("dmem_req", 32'(dmem_req), 32'(acc));
            if (k == 0 && acc) begin
                check("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                check("dmem_be", 32'(dmem_be), 32'(m_be(sz, alu)));
                check("dmem_we", 32'(dmem_we), 32'(we));
                if (we) check("dmem_wdata", dmem_wdata, m_wdata(sz, mux ? imm : wd));
            end
            if (exp_stall) stalls++;
            @(posedge clk);
            #1;
            if (exp_stall) begin
                check("bubble_rw", 32'(RegWriteW), 32'd0);
                check("bubble_err", 32'(mem_err_w), 32'd0);
            end
            @(negedge clk);
            if (!exp_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("cycle_bound", 32'd0, 32'd1);
        check("stall_cycles", 32'(stalls), 32'(!acc ? 0 : (d < TMO ? d : TMO)));
        check("RegWriteW", 32'(RegWriteW), 32'((mis || tmo) ? 1'b0 : rw));
        check("mem_err_w", 32'(mem_err_w), mis ? 32'd1 : (tmo ? 32'd2 : 32'd0));
        check("RD_W", 32'(RD_W), 32'(rd));
        if (!mis && !tmo) begin
            check("ResultSrcW", 32'(ResultSrcW), 32'(rs));
            check("ALU_ResultW", ALU_ResultW, alu);
            check("PCPlus4W", PCPlus4W, pc4);
            check("PCPlus_offsetW", PCPlus_offsetW, pco);
            check("Immediate_valueW", Immediate_valueW, imm);
            if (acc && !we) check("ReadDataW", ReadDataW, m_load(sz, alu, sgn, rdata));
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        bit sel;
        int sz, d, r;
        logic [31:0] addr;

        rst = 1'b1;
        dmem_ack = 1'b0;  dmem_rdata = '0;
        RegWriteM = 1'b1;  MemWriteM = 1'b0;  Memory_selectorM = 1'b1;  ResultSrcM = '0;
        RD_M = 5'd3;  MuxsignM = 1'b0;  MUXWDMemwriteM = 1'b0;  SignExM = 2'b10;
        ALU_ResultM = 32'h40;  WriteDataM = '0;  Immediate_valueM = '0;
        PCPlus4M = '0;  PCPlus_offsetM = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_rw", 32'(RegWriteW), 32'd0);
        check("rst_err", 32'(mem_err_w), 32'd0);
        check("rst_rd", 32'(RD_W), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_instr(1, 0, 0, 3'd1, 5'd5, 0, 0, 2, 32'h1234, 0, 0, 32'h8, 32'hC, 0, 0);
        run_instr(1, 0, 1, 3'd1, 5'd6, 1, 0, 0, 32'h103, 0, 0, 32'h10, 32'h14, 32'h80FF_0011, 0);
        run_instr(0, 1, 1, 3'd0, 5'd0, 0, 0, 1, 32'h202, 32'h0000_ABCD, 32'h55, 32'h18, 32'h1C,
                  0, 3);
        run_instr(1, 0, 1, 3'd1, 5'd7, 0, 0, 2, 32'h006, 0, 0, 32'h20, 32'h24, 32'h1111_2222, 0);
        run_instr(1, 0, 1, 3'd1, 5'd8, 0, 0, 2, 32'h040, 0, 0, 32'h28, 32'h2C, 32'h3333_4444, 99);
        run_instr(1, 0, 1, 3'd1, 5'd9, 0, 0, 2, 32'h044, 0, 0, 32'h30, 32'h34, 32'h5555_6666, TMO);

        // Reset while waiting for an ack, then a late ack
        RegWriteM = 1'b1;  MemWriteM = 1'b0;  Memory_selectorM = 1'b1;  SignExM = 2'b10;
        ALU_ResultM = 32'h80;  RD_M = 5'd4;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_stall", 32'(stall_m), 32'd0);
        check("midrst_alu", ALU_ResultW, 32'd0);
        check("midrst_rd", 32'(RD_W), 32'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        Memory_selectorM = 1'b0;  ALU_ResultM = 32'h5555;  RD_M = 5'd7;
        #1;
        check("late_ack_stall", 32'(stall_m), 32'd0);
        check("late_ack_req", 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        check("late_ack_alu", ALU_ResultW, 32'h5555);
        check("late_ack_err", 32'(mem_err_w), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        run_instr(1, 0, 1, 3'd1, 5'd10, 0, 0, 1, 32'h122, 0, 0, 32'h38, 32'h3C, 32'h8001_7FFF, 2);

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            sel = ($urandom % 10) < 7;
            sz = $urandom % 4;
            addr = $urandom;
            if (($urandom % 10) < 7) begin
                if (sz == 1) addr[0] = 1'b0;
                else if (sz >= 2) addr[1:0] = 2'b00;
            end
            r = $urandom % 10;
            if (r < 5) d = 0;
            else if (r < 9) d = $urandom_range(1, 5);
            else d = $urandom_range(TMO - 2, TMO + 3);
            run_instr(1'($urandom), 1'($urandom), sel, 3'($urandom), 5'($urandom), 1'($urandom),
                      1'($urandom), sz, addr, $urandom, $urandom, $urandom, $urandom, $urandom,
                      d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
